// File: rtl/prog_mem_loader.sv
// prog_mem_loader: program memory and instruction-side responder for the 8-bit core.
// It takes a program over a byte-stream valid/ready port, pads the unwritten tail
// with the FILL opcode, and keeps the core in reset (cpu_clb low) until the image
// is complete. In RUN it returns mem[pc] combinationally. Outside RUN it returns FILL.
module prog_mem_loader #(
  parameter int         DEPTH = 256,   // program bytes; must not exceed 256 (pc is 8 bits)
  parameter logic [7:0] FILL  = 8'h00  // pad opcode, also driven outside RUN
) (
  input  logic       clk,
  input  logic       clb,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic [7:0] pc,
  output logic [7:0] instruction,
  output logic       cpu_clb,
  output logic       busy,
  output logic [8:0] prog_len
);

  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(0);
  localparam logic [AW-1:0] ONE_ADDR  = AW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  logic [1:0]    r_state;
  logic [AW-1:0] r_wptr;
  logic [8:0]    r_prog_len;
  logic          r_cpu_clb;
  logic [7:0]    r_mem [DEPTH];

  logic [1:0]    w_state_nxt;
  logic [AW-1:0] w_wptr_nxt;
  logic [8:0]    w_len_nxt;
  logic          w_mem_we;
  logic [7:0]    w_mem_wdata;
  logic [AW-1:0] w_rd_addr;

  // Only the low address bits select a byte; with DEPTH=256 this is all of pc.
  assign w_rd_addr = pc[AW-1:0];

  // Next-state, write-pointer, length and memory-write decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_len_nxt   = r_prog_len;
    w_mem_we    = 1'b0;
    w_mem_wdata = FILL;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          w_state_nxt = ST_LOAD;
          w_wptr_nxt  = ZERO_ADDR;
          w_len_nxt   = 9'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LOAD: begin
        // load_ready is 1 throughout LOAD, so load_valid alone is a handshake.
        if (load_valid) begin
          w_mem_we    = 1'b1;
          w_mem_wdata = load_data;
          w_len_nxt   = r_prog_len + 9'd1;
          if (r_wptr == LAST_ADDR) begin
            // Image full (with or without load_last): nothing left to pad.
            w_state_nxt = ST_RUN;
          end else if (load_last) begin
            w_wptr_nxt  = r_wptr + ONE_ADDR;
            w_state_nxt = ST_PAD;
          end else begin
            w_wptr_nxt  = r_wptr + ONE_ADDR;
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_PAD: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = FILL;
        if (r_wptr == LAST_ADDR) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_wptr_nxt  = r_wptr + ONE_ADDR;
          w_state_nxt = ST_PAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control state; cpu_clb is registered so it rises on the edge that enters RUN.
  always_ff @(posedge clk or negedge clb) begin
    if (!clb) begin
      r_state    <= ST_IDLE;
      r_wptr     <= ZERO_ADDR;
      r_prog_len <= 9'd0;
      r_cpu_clb  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wptr     <= w_wptr_nxt;
      r_prog_len <= w_len_nxt;
      r_cpu_clb  <= (w_state_nxt == ST_RUN);
    end
  end

  // Program storage. It is deliberately not reset, so a reset keeps the old image.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wptr] <= w_mem_wdata;
    end
  end

  // Zero-latency fetch in RUN, so the core's IR captures on the same edge pc is valid.
  always_comb begin
    if (r_state == ST_RUN) begin
      instruction = r_mem[w_rd_addr];
    end else begin
      instruction = FILL;
    end
  end

  assign load_ready = (r_state == ST_LOAD);
  assign busy       = (r_state == ST_LOAD) || (r_state == ST_PAD);
  assign cpu_clb    = r_cpu_clb;
  assign prog_len   = r_prog_len;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader. The bench keeps its own model of
// the program image. Expected fetch results are queued when a read is
// requested and compared when the DUT drives instruction.
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       clb = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic [7:0] pc = 8'h00;
  logic       load_ready;
  logic [7:0] instruction;
  logic       cpu_clb;
  logic       busy;
  logic [8:0] prog_len;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_mem [256];
  logic [7:0] rd_addr_q [$];
  logic [7:0] rd_exp_q [$];
  int wp;         // model write pointer for the current load
  int ld_cycles;  // cycles spent driving bytes during the current load
  int busy_cnt;   // negedges at which busy was seen high since load_start

  always #5 clk = ~clk;

  prog_mem_loader #(.DEPTH(256), .FILL(8'h00)) dut (
    .clk         (clk),
    .clb         (clb),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .pc          (pc),
    .instruction (instruction),
    .cpu_clb     (cpu_clb),
    .busy        (busy),
    .prog_len    (prog_len)
  );

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (busy === 1'b1) busy_cnt++;
  endtask

  // Pulse load_start with a stray byte on load_valid; only the start may act.
  task automatic do_start();
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h99;
    load_last  = 1'b0;
    #1;
    check("pre_start_ready", load_ready, 1'b0);
    busy_cnt  = 0;
    wp        = 0;
    ld_cycles = 0;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_ready", load_ready, 1'b1);
    check("start_cpu_clb", cpu_clb, 1'b0);
    check("start_len", prog_len, 9'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic v, input logic last, input logic exp_acc);
    load_valid = v;
    load_data  = d;
    load_last  = last;
    #1;
    check("ld_ready", load_ready, exp_acc);
    check("ld_instr", instruction, 8'h00);
    check("ld_cpu_clb", cpu_clb, 1'b0);
    tick();
    ld_cycles++;
    if (v && exp_acc) begin
      exp_mem[wp] = d;
      wp++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Wait (bounded) for the image to complete, then check RUN outputs.
  task automatic wait_run(input int exp_len);
    for (int n = 0; n < 600 && busy === 1'b1; n++) tick();
    for (int a = wp; a < 256; a++) exp_mem[a] = 8'h00;
    check("run_busy", busy, 1'b0);
    check("run_cpu_clb", cpu_clb, 1'b1);
    check("run_ready", load_ready, 1'b0);
    check("prog_len", prog_len, exp_len);
    check("busy_cycles", busy_cnt, ld_cycles + (256 - exp_len));
  endtask

  task automatic queue_read(input logic [7:0] a);
    rd_addr_q.push_back(a);
    rd_exp_q.push_back(exp_mem[a]);
  endtask

  task automatic drain_reads();
    logic [7:0] a;
    while (rd_addr_q.size() > 0) begin
      a  = rd_addr_q.pop_front();
      pc = a;
      #1;
      check($sformatf("rd[%0h]", a), instruction, rd_exp_q.pop_front());
      tick();
    end
  endtask

  task automatic short_load();
    do_start();
    send_byte(8'h1A, 1'b1, 1'b0, 1'b1);
    send_byte(8'h2B, 1'b1, 1'b0, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_run(3);
    check("short_busy_total", busy_cnt, 256);
    queue_read(8'h00);
    queue_read(8'h01);
    queue_read(8'h02);
    queue_read(8'h03);
    queue_read(8'hFF);
    drain_reads();
  endtask

  initial begin
    // Reset then idle
    clb = 1'b0;
    pc  = 8'h05;
    busy_cnt = 0;
    tick();
    tick();
    check("rst_cpu_clb", cpu_clb, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_instr", instruction, 8'h00);
    clb = 1'b1;
    tick();
    check("idle_cpu_clb", cpu_clb, 1'b0);
    check("idle_instr", instruction, 8'h00);
    check("idle_busy", busy, 1'b0);
    check("idle_ready", load_ready, 1'b0);
    check("idle_len", prog_len, 9'd0);

    // Short load
    short_load();

    // Reload from RUN with a 1-byte program; addr 1 (was 2B) is padded to 00
    do_start();
    send_byte(8'h77, 1'b1, 1'b1, 1'b1);
    wait_run(1);
    queue_read(8'h00);
    queue_read(8'h01);
    queue_read(8'h02);
    drain_reads();
    check("reload_addr1_model", exp_mem[1], 8'h00);

    // Backpressure / gaps on load_valid
    do_start();
    send_byte(8'h11, 1'b1, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b0, 1'b0, 1'b1);
    send_byte(8'hEE, 1'b0, 1'b0, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1, 1'b1);
    wait_run(2);
    queue_read(8'h00);
    queue_read(8'h01);
    queue_read(8'h02);
    drain_reads();

    // Full image, no load_last: RUN right after byte 255, no PAD
    do_start();
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b1);
    check("full_no_pad_busy", busy, 1'b0);
    check("full_no_pad_clb", cpu_clb, 1'b1);
    wait_run(256);
    load_valid = 1'b1;
    load_data  = 8'hAB;
    #1;
    check("full_257_ready", load_ready, 1'b0);
    tick();
    load_valid = 1'b0;
    check("full_257_len", prog_len, 9'd256);
    queue_read(8'hFF);
    queue_read(8'h00);
    queue_read(8'h80);
    drain_reads();

    // Async reset in the middle of LOAD
    do_start();
    send_byte(8'h5A, 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
    pc = 8'h00;
    #2;
    clb = 1'b0;
    #1;
    check("arst_cpu_clb", cpu_clb, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_instr", instruction, 8'h00);
    check("arst_ready", load_ready, 1'b0);
    check("arst_len", prog_len, 9'd0);
    #1;
    clb = 1'b1;
    tick();
    tick();
    check("arst_idle_busy", busy, 1'b0);
    check("arst_idle_cpu_clb", cpu_clb, 1'b0);
    check("arst_idle_instr", instruction, 8'h00);

    // A full load after the abort behaves like the short load
    short_load();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Instruction-side responder for the 8-bit processor core: owns the program memory and returns the instruction byte for the core's `pc` every cycle.
- Loads a program from a byte-stream valid/ready interface, then pads the unwritten tail with a fill opcode.
- Holds the core in reset through its own `cpu_clb` output until the program is resident.
- Sits between the host/boot interface and the core's `instruction`/`pc`/`clb` pins.

Parameters:
- DEPTH, 256, number of program bytes; addressed by the 8-bit `pc`.
- FILL, 8'h00, opcode written to unloaded locations and driven on `instruction` outside RUN.

Ports:
- clk  input  1  system clock, rising edge.
- clb  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle request to begin a program load.
- load_valid  input  1  `load_data` valid.
- load_data  input  8  program byte.
- load_last  input  1  qualifies the final byte of the program (sampled with `load_valid`).
- load_ready  output  1  block accepts a byte this cycle.
- pc  input  8  fetch address from the core.
- instruction  output  8  fetched byte to the core.
- cpu_clb  output  1  active-low reset to the core.
- busy  output  1  high in LOAD or PAD.
- prog_len  output  9  bytes accepted by the most recent load (0..DEPTH).

Behaviour:
- States: IDLE, LOAD, PAD, RUN.
- Reset (`clb` low, asynchronous) puts the block in this state:
  - state IDLE, wptr 0, prog_len 0, cpu_clb 0.
  - busy 0, load_ready 0, instruction = FILL.
  - Memory contents are not cleared.
- Reset mid-LOAD or mid-PAD aborts to IDLE. The partial image is retained but never served.
- IDLE:
  - cpu_clb 0; instruction = FILL.
  - load_start -> LOAD on the next edge, with wptr=0 and prog_len=0.
- LOAD:
  - load_ready = 1 (combinational from state).
  - Each cycle with load_valid & load_ready: mem[wptr] <= load_data; wptr++, prog_len++.
  - Handshake with load_last=1 -> PAD. If wptr was DEPTH-1, go to RUN instead (nothing to pad).
  - Handshake at wptr=DEPTH-1 without load_last -> image full: prog_len=DEPTH, go to RUN. Later bytes are not accepted.
  - load_start during LOAD is ignored.
- PAD:
  - load_ready 0.
  - Each cycle mem[wptr] <= FILL and wptr++.
  - The write at wptr=DEPTH-1 -> RUN. PAD therefore lasts DEPTH - prog_len cycles.
  - load_start is ignored.
- RUN:
  - cpu_clb = 1, registered: it rises on the same edge that enters RUN.
  - instruction = mem[pc], combinational read with zero latency, so the core's IR can capture it on the same edge that `pc` is valid.
  - load_start -> LOAD: cpu_clb falls on that edge and the core is held in reset again.
- Outside RUN, instruction = FILL regardless of `pc`.
- busy = (state==LOAD || state==PAD).
- Simultaneous load_start and load_valid in IDLE or RUN: only the start takes effect. The byte is not accepted because load_ready is 0 that cycle.
- prog_len holds its value through PAD and RUN until the next load_start.
- Arithmetic: wptr is log2(DEPTH) bits and never wraps. The transitions above stop it at DEPTH-1. prog_len is 9-bit so it can represent DEPTH.

Test Plan:
- Reset then idle: clb low 2 cycles then high, pc=8'h05 -> cpu_clb=0, instruction=8'h00, busy=0, load_ready=0, prog_len=0.
- Short load: load_start; bytes 8'h1A, 8'h2B, 8'h3C with load_last on 8'h3C, load_valid held high -> prog_len=3, busy for 3+253 cycles after load_start. Then cpu_clb=1; pc=0,1,2,3,255 read 8'h1A, 8'h2B, 8'h3C, 8'h00, 8'h00.
- Backpressure/gaps: load_valid toggled 1,0,0,1 with data 8'h11, 8'hFF(invalid), 8'hEE(invalid), 8'h22 (load_last) -> only 8'h11 at addr 0 and 8'h22 at addr 1 are written; prog_len=2.
- Full image: 256 bytes (data = address) with no load_last -> RUN entered on the edge after byte 255 with no PAD cycles; prog_len=256; pc=8'hFF reads 8'hFF. A 257th load_valid is not accepted (load_ready=0).
- Reload from RUN: in RUN, load_start -> cpu_clb 0 on the next edge. New 1-byte program 8'h77 -> addr 0 = 8'h77, addr 1 (previously 8'h2B) = 8'h00 after PAD.
- Async reset mid-LOAD: after 2 bytes accepted, pulse clb low between clock edges -> outputs immediately at reset values (cpu_clb=0, busy=0, instruction=8'h00). A subsequent full load behaves as in the short-load scenario.
